// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding and one-hot helper for the ADC sequencer
package adc_seq_pkg;
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PWR    = 3'd1,
    ADV    = 3'd2,
    SETTLE = 3'd3,
    SOC    = 3'd4,
    WAIT   = 3'd5
  } state_e;
  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 16; i++) if (oh[i]) oh2idx = 4'(i);
  endfunction
endpackage

// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: bundles the run/mask/eoc inputs and the ADC/sample outputs of the sequencer
// master drives en, ch_mask, eoc; slave (the sequencer) drives soc, pd, sel, ch_idx, busy, smp_vld, smp_ch, err
interface adc_seq_ctrl_if #(
  parameter int N_CH = 3,
  parameter int CH_W = $clog2(N_CH)
);
  logic            en;
  logic [N_CH-1:0] ch_mask;
  logic            eoc;
  logic            soc;
  logic            pd;
  logic [N_CH-1:0] sel;
  logic [CH_W-1:0] ch_idx;
  logic            busy;
  logic            smp_vld;
  logic [CH_W-1:0] smp_ch;
  logic            err;
  modport master (output en, ch_mask, eoc, input soc, pd, sel, ch_idx, busy, smp_vld, smp_ch, err);
  modport slave  (input en, ch_mask, eoc, output soc, pd, sel, ch_idx, busy, smp_vld, smp_ch, err);
endinterface

// File: rtl/adc_rr_pick.sv
// adc_rr_pick: combinational round-robin finder of the next enabled channel
// in: mask (enabled channels), cur (current index), first (search from 0 inclusive)
// out: found (any channel enabled), nxt (chosen index)
module adc_rr_pick #(
  parameter int N_CH = 3,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  input  logic            first,
  output logic            found,
  output logic [CH_W-1:0] nxt
);
  typedef logic [CH_W:0] ext_t;
  ext_t base;
  // base + k never exceeds 2*N_CH-1, so one conditional subtract wraps it
  function automatic logic [CH_W-1:0] wrap(input ext_t b, input int k);
    ext_t s;
    s = b + ext_t'(k);
    return CH_W'(s >= ext_t'(N_CH) ? s - ext_t'(N_CH) : s);
  endfunction
  assign base  = first ? '0 : {1'b0, cur} + 1'b1;
  assign found = |mask;
  // scanning downward lets the nearest candidate win
  always_comb begin
    nxt = '0;
    for (int k = N_CH - 1; k >= 0; k--) if (mask[wrap(base, k)]) nxt = wrap(base, k);
  end
endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: powers up a SAR ADC then round-robins conversions over a masked set of mux channels
// ports: clk, rst (async, active high), bus (adc_seq_ctrl_if.slave: en, ch_mask, eoc in;
// soc, pd, sel, ch_idx, busy, smp_vld, smp_ch, err out)
// ADC_SEQ_TIMEOUT_EN: bounds WAIT by TMO_CYC cycles and raises sticky err on expiry
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int CH_W       = $clog2(N_CH),
  parameter int PD_CYC     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
`ifdef ADC_SEQ_TIMEOUT_EN
  , parameter int TMO_CYC  = 200
`endif
) (
  input logic           clk,
  input logic           rst,
  adc_seq_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] PD_LD = CNT_W'(PD_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LD = CNT_W'(SETTLE_CYC - 1);
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TMO_CYC - 1);
  logic err_q, err_d;
`endif
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;
  logic [N_CH-1:0] sel_q, sel_d;
  logic [CH_W-1:0] ch_idx_q, ch_idx_d;
  logic            soc_q, soc_d;
  logic            pd_q, pd_d;
  logic            busy_q, busy_d;
  logic            smp_vld_q, smp_vld_d;
  logic [CH_W-1:0] smp_ch_q, smp_ch_d;
  logic            found;
  logic [CH_W-1:0] nxt;
  adc_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .mask (bus.ch_mask),
    .cur  (ch_idx_q),
    .first(first_q),
    .found(found),
    .nxt  (nxt)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    sel_d     = sel_q;
    ch_idx_d  = ch_idx_q;
    smp_vld_d = 1'b0;
    smp_ch_d  = smp_ch_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      OFF: if (bus.en) begin
        state_d = PWR;
        cnt_d   = PD_LD;
        first_d = 1'b1;
      end
      PWR: begin
        if (!bus.en) state_d = OFF;
        else if (cnt_q == '0) state_d = ADV;
        else cnt_d = cnt_q - 1'b1;
      end
      ADV: begin
        if (!bus.en) state_d = OFF;
        else if (found) begin
          state_d     = SETTLE;
          cnt_d       = ST_LD;
          first_d     = 1'b0;
          ch_idx_d    = nxt;
          sel_d       = '0;
          sel_d[nxt]  = 1'b1;
        end else sel_d = '0;
      end
      SETTLE: begin
        if (!bus.en) state_d = OFF;
        else if (cnt_q == '0) state_d = SOC;
        else cnt_d = cnt_q - 1'b1;
      end
      SOC: begin
        state_d = WAIT;
`ifdef ADC_SEQ_TIMEOUT_EN
        cnt_d   = TMO_LD;
`endif
      end
      WAIT: begin
        // a started conversion always completes, even if en has dropped
        if (bus.eoc) begin
          smp_vld_d = 1'b1;
          smp_ch_d  = CH_W'(oh2idx(16'(sel_q)));
          state_d   = bus.en ? ADV : OFF;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = bus.en ? ADV : OFF;
        end else cnt_d = cnt_q - 1'b1;
`endif
      end
      default: state_d = OFF;
    endcase
    if (state_d == OFF) sel_d = '0;
    pd_d   = state_d == PWR;
    soc_d  = state_d == SOC;
    busy_d = state_d != OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      sel_q     <= '0;
      ch_idx_q  <= '0;
      soc_q     <= 1'b0;
      pd_q      <= 1'b0;
      busy_q    <= 1'b0;
      smp_vld_q <= 1'b0;
      smp_ch_q  <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      sel_q     <= sel_d;
      ch_idx_q  <= ch_idx_d;
      soc_q     <= soc_d;
      pd_q      <= pd_d;
      busy_q    <= busy_d;
      smp_vld_q <= smp_vld_d;
      smp_ch_q  <= smp_ch_d;
`ifdef ADC_SEQ_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  assign bus.soc     = soc_q;
  assign bus.pd      = pd_q;
  assign bus.sel     = sel_q;
  assign bus.ch_idx  = ch_idx_q;
  assign bus.busy    = busy_q;
  assign bus.smp_vld = smp_vld_q;
  assign bus.smp_ch  = smp_ch_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif
endmodule
